// File: rtl/fetch_queue.sv
// Instruction prefetcher: reads memory at the PC, pulses the PC increment per
// completed read and buffers {address, word} pairs in a small FIFO for the decoder.
module fetch_queue #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 16,
   parameter  int AW    = 16,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             reset_bar,
   input  logic [AW-1:0]    pc_value_i,
   output logic             pc_inc_o,
   input  logic             flush_bar_i,
   output logic [AW-1:0]    mem_addr_o,
   output logic             mem_rd_o,
   input  logic             mem_ready_i,
   input  logic [WIDTH-1:0] mem_data_i,
   output logic [WIDTH-1:0] instr_o,
   output logic [AW-1:0]    instr_addr_o,
   output logic             instr_valid_o,
   input  logic             instr_take_i,
   output logic [CW-1:0]    count_o,
   output logic [1:0]       state_o
);

   // Handshake: mem_rd_o stays high with mem_addr_o stable until a cycle with
   // mem_ready_i=1; that cycle transfers mem_data_i and pc_inc_o pulses with it.
   // On the decoder side instr_valid_o & instr_take_i pops the head entry.

   // IDLE is encoded as 0 so the debug state reads 0 throughout reset.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [AW-1:0]    addr_q [DEPTH];

   logic push;
   logic pop;

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q < CW'(DEPTH)) begin
               state_d    = REQ;
               mem_addr_d = pc_value_i;
            end
         end
         REQ: begin
            if (mem_ready_i) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A jump wins over everything: the read in flight and its data are dropped.
      if (!flush_bar_i) begin
         state_d    = FLUSH;
         mem_addr_d = mem_addr_q;
         push       = 1'b0;
      end
   end

   assign pop = instr_take_i && (count_q != '0) && flush_bar_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (!flush_bar_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= mem_data_i;
         addr_q[wr_ptr_q] <= mem_addr_q;
      end
   end

   assign mem_rd_o      = (state_q == REQ) && flush_bar_i;
   assign mem_addr_o    = mem_addr_q;
   assign pc_inc_o      = push;
   assign instr_valid_o = (count_q != '0);
   assign instr_o       = instr_valid_o ? data_q[rd_ptr_q] : '0;
   assign instr_addr_o  = instr_valid_o ? addr_q[rd_ptr_q] : '0;
   assign count_o       = count_q;
   assign state_o       = state_q;

endmodule
